// File: rtl/mux_pkg.sv
// mux_pkg: shared mode/lock encodings and a clog2 helper for the mux_rr_n selector
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    typedef enum logic {IDLE, LOCKED} lock_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_n_rr_pick.sv
// rr_pick: combinational rotate-priority search, first request after ptr with wrap
module rr_pick
    import mux_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = 2
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] idx,
    output logic            found
);

    logic [SELW-1:0] j;

    // scan from farthest to nearest so the closest request after ptr wins
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = NCH; k >= 1; k--) begin
            j = SELW'((int'(ptr) + k) % NCH);
            if (req[j]) begin
                idx   = j;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_n.sv
// mux_rr_n: N-channel valid/ready selector, manual or round-robin, registered output; MUX_RR_LOCK_EN adds in_last packet locking
module mux_rr_n
    import mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    localparam int SELW  = clog2(NCH) < 1 ? 1 : clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
`ifdef MUX_RR_LOCK_EN
    input  logic [NCH-1:0]       in_last,
`endif
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      grant
);

    logic             can_load;
    logic             has;
    logic             load;
    logic             rr_found;
    logic [SELW-1:0]  cand;
    logic [SELW-1:0]  rr_idx;
    logic [SELW-1:0]  rr_ptr;
    logic [WIDTH-1:0] ch [NCH];
`ifdef MUX_RR_LOCK_EN
    lock_state_t      state;
    logic [SELW-1:0]  lock_ch;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign ch[i] = in_data[i*WIDTH +: WIDTH];
    end

    rr_pick #(.NCH(NCH), .SELW(SELW)) u_pick (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .idx   (rr_idx),
        .found (rr_found)
    );

    // pick the candidate channel and offer it a single in_ready when the output can take a word
    always_comb begin
`ifdef MUX_RR_LOCK_EN
        cand = state == LOCKED ? lock_ch : mode == MODE_RR ? rr_idx : sel;
        has  = state == LOCKED | (mode == MODE_RR ? rr_found : int'(sel) < NCH);
`else
        cand = mode == MODE_RR ? rr_idx : sel;
        has  = mode == MODE_RR ? rr_found : int'(sel) < NCH;
`endif
        can_load = !out_valid | out_ready;
        load     = can_load & has & in_valid[cand];
        in_ready = can_load & has ? NCH'(1) << cand : '0;
    end

    // output register, round-robin pointer and packet lock tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            grant     <= '0;
            rr_ptr    <= SELW'(NCH - 1);
`ifdef MUX_RR_LOCK_EN
            state     <= IDLE;
            lock_ch   <= '0;
`endif
        end else begin
            if (load) begin
                out_data  <= ch[cand];
                out_valid <= 1'b1;
                grant     <= cand;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
`ifdef MUX_RR_LOCK_EN
            if (load && state == IDLE) begin
                if (mode == MODE_RR) rr_ptr <= cand;
                if (!in_last[cand]) begin
                    state   <= LOCKED;
                    lock_ch <= cand;
                end
            end else if (load && in_last[cand]) begin
                state  <= IDLE;
                rr_ptr <= lock_ch;
            end
`else
            if (load && mode == MODE_RR) rr_ptr <= cand;
`endif
        end
    end

endmodule

// File: tb/tb_mux_rr_n.sv
// tb_mux_rr_n: randomized and directed checks of mux_rr_n against a behavioural model
module tb_mux_rr_n;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  grant;
    logic [7:0]  d [4];
    logic [31:0] in_data;
`ifdef MUX_RR_LOCK_EN
    logic [3:0]  in_last;
    logic [2:0]  il3;
`endif

    logic [2:0]  v3;
    logic [2:0]  ird3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [7:0]  od3;
    logic        ov3;
    logic        ordy3;
    logic [1:0]  g3;
    logic [7:0]  d3 [3];
    logic [23:0] in_data3;

    int          nvec;
    int          nerr;

    logic        m_valid;
    logic [7:0]  m_data;
    logic [1:0]  m_grant;
    int          m_last;
    logic        m_lock;
    int          m_lock_ch;
    logic [3:0]  e_rdy;
    logic [3:0]  o_rdy;
    logic [2:0]  r3;

    assign in_data  = {d[3], d[2], d[1], d[0]};
    assign in_data3 = {d3[2], d3[1], d3[0]};

    mux_rr_n #(.WIDTH(8), .NCH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef MUX_RR_LOCK_EN
        .in_last   (in_last),
`endif
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant)
    );

    mux_rr_n #(.WIDTH(8), .NCH(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data3),
        .in_valid  (v3),
        .in_ready  (ird3),
`ifdef MUX_RR_LOCK_EN
        .in_last   (il3),
`endif
        .mode      (mode3),
        .sel       (sel3),
        .out_data  (od3),
        .out_valid (ov3),
        .out_ready (ordy3),
        .grant     (g3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_cand();
`ifdef MUX_RR_LOCK_EN
        if (m_lock) return m_lock_ch;
`endif
        if (mode == 1'b0) return int'(sel);
        for (int k = 1; k <= 4; k++)
            if (in_valid[(m_last + k) % 4]) return (m_last + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid   = 1'b0;
        m_data    = '0;
        m_grant   = '0;
        m_last    = 3;
        m_lock    = 1'b0;
        m_lock_ch = 0;
    endtask

    task automatic step();
        int   c;
        logic can;
        logic ld;
        @(negedge clk);
        c     = model_cand();
        can   = !m_valid || out_ready;
        ld    = can && c >= 0 && in_valid[c[1:0]];
        e_rdy = (can && c >= 0) ? 4'(1 << c) : 4'b0;
        o_rdy = in_ready;
        r3    = ird3;
        @(posedge clk);
        #1;
        if (ld) begin
            m_valid = 1'b1;
            m_data  = d[c[1:0]];
            m_grant = c[1:0];
`ifdef MUX_RR_LOCK_EN
            if (m_lock) begin
                if (in_last[c[1:0]]) begin
                    m_lock = 1'b0;
                    m_last = m_lock_ch;
                end
            end else begin
                if (mode) m_last = c;
                if (!in_last[c[1:0]]) begin
                    m_lock    = 1'b1;
                    m_lock_ch = c;
                end
            end
`else
            if (mode) m_last = c;
`endif
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        in_valid  = 4'hf;
        mode      = 1'b1;
        sel       = 2'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = 8'hA0 + 8'(i);
        repeat (2) @(posedge clk);
        #1;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        nvec++; if (grant !== 2'd0) begin nerr++; $display("FAIL reset_grant: got %0d want 0", grant); end
        nvec++; if (out_data !== 8'h00) begin nerr++; $display("FAIL reset_data: got %h want 00", out_data); end
        rst = 1'b0;
        model_reset();
        step();
        nvec++; if (grant !== 2'd0) begin nerr++; $display("FAIL first_grant: got %0d want 0", grant); end
        nvec++; if (out_data !== 8'hA0 || out_valid !== 1'b1) begin nerr++; $display("FAIL first_word: got %h/%b want a0/1", out_data, out_valid); end
    endtask

    task automatic test_rr_all();
        do_reset();
        in_valid  = 4'hf;
        mode      = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            nvec++; if (grant !== 2'(i % 4)) begin nerr++; $display("FAIL rr_all_grant: got %0d want %0d", grant, i % 4); end
            nvec++; if (out_data !== 8'hA0 + 8'(i % 4)) begin nerr++; $display("FAIL rr_all_data: got %h want %h", out_data, 8'hA0 + 8'(i % 4)); end
            nvec++; if (o_rdy !== e_rdy) begin nerr++; $display("FAIL rr_all_ready: got %b want %b", o_rdy, e_rdy); end
        end
    endtask

    task automatic test_rr_pair();
        in_valid = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            step();
            nvec++; if (grant !== (i % 2 == 1 ? 2'd3 : 2'd2)) begin nerr++; $display("FAIL rr_pair_grant: got %0d want %0d", grant, i % 2 == 1 ? 3 : 2); end
            nvec++; if (o_rdy[1:0] !== 2'b00) begin nerr++; $display("FAIL rr_pair_ready: got %b want 00", o_rdy[1:0]); end
        end
    endtask

    task automatic test_manual_stall();
        do_reset();
        mode      = 1'b0;
        sel       = 2'd1;
        in_valid  = 4'b0010;
        d[1]      = 8'h5A;
        out_ready = 1'b1;
        step();
        nvec++; if (out_data !== 8'h5A || out_valid !== 1'b1) begin nerr++; $display("FAIL manual_load: got %h/%b want 5a/1", out_data, out_valid); end
        out_ready = 1'b0;
        d[1]      = 8'h5B;
        for (int i = 0; i < 3; i++) begin
            step();
            nvec++; if (out_data !== 8'h5A || out_valid !== 1'b1) begin nerr++; $display("FAIL manual_hold: got %h/%b want 5a/1", out_data, out_valid); end
            nvec++; if (o_rdy[1] !== 1'b0) begin nerr++; $display("FAIL manual_stall_ready: got %b want 0", o_rdy[1]); end
        end
        out_ready = 1'b1;
        step();
        nvec++; if (o_rdy[1] !== 1'b1) begin nerr++; $display("FAIL manual_resume_ready: got %b want 1", o_rdy[1]); end
        nvec++; if (out_data !== 8'h5B || out_valid !== 1'b1) begin nerr++; $display("FAIL manual_resume_data: got %h/%b want 5b/1", out_data, out_valid); end
    endtask

    task automatic test_nch3();
        do_reset();
        mode3 = 1'b0;
        sel3  = 2'd3;
        v3    = 3'b111;
        ordy3 = 1'b1;
        for (int i = 0; i < 3; i++) d3[i] = 8'hC0 + 8'(i);
        for (int i = 0; i < 3; i++) begin
            step();
            nvec++; if (r3 !== 3'b000) begin nerr++; $display("FAIL nch3_ready: got %b want 000", r3); end
            nvec++; if (ov3 !== 1'b0) begin nerr++; $display("FAIL nch3_valid: got %b want 0", ov3); end
        end
        mode3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            nvec++; if (g3 !== 2'(i % 3) || ov3 !== 1'b1) begin nerr++; $display("FAIL nch3_grant: got %0d/%b want %0d/1", g3, ov3, i % 3); end
            nvec++; if (od3 !== 8'hC0 + 8'(i % 3)) begin nerr++; $display("FAIL nch3_data: got %h want %h", od3, 8'hC0 + 8'(i % 3)); end
        end
        v3 = 3'b000;
    endtask

`ifdef MUX_RR_LOCK_EN
    task automatic test_lock();
        int seq [5];
        seq       = '{1, 1, 1, 2, 0};
        do_reset();
        mode      = 1'b1;
        out_ready = 1'b1;
        in_last   = 4'b1111;
        in_valid  = 4'b0001;
        step();
        nvec++; if (grant !== 2'd0) begin nerr++; $display("FAIL lock_pre_grant: got %0d want 0", grant); end
        in_valid = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            in_last = (i == 2) ? 4'b1111 : 4'b1101;
            step();
            nvec++; if (grant !== 2'(seq[i])) begin nerr++; $display("FAIL lock_grant: got %0d want %0d", grant, seq[i]); end
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            in_valid  = 4'($urandom);
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
`ifdef MUX_RR_LOCK_EN
            in_last = 4'($urandom);
`endif
            step();
            nvec++; if (o_rdy !== e_rdy || $countones(o_rdy) > 1) begin nerr++; $display("FAIL rand_ready: got %b want %b", o_rdy, e_rdy); end
            nvec++; if (out_valid !== m_valid) begin nerr++; $display("FAIL rand_valid: got %b want %b", out_valid, m_valid); end
            if (m_valid) begin
                nvec++; if (out_data !== m_data || grant !== m_grant) begin nerr++; $display("FAIL rand_word: got %h/%0d want %h/%0d", out_data, grant, m_data, m_grant); end
            end
        end
    endtask

    initial begin
        nvec  = 0;
        nerr  = 0;
        rst   = 1'b1;
        v3    = 3'b000;
        mode3 = 1'b0;
        sel3  = 2'd0;
        ordy3 = 1'b1;
        for (int i = 0; i < 3; i++) d3[i] = 8'h00;
`ifdef MUX_RR_LOCK_EN
        in_last = 4'b1111;
        il3     = 3'b111;
`endif
        model_reset();
        test_reset();
        test_rr_all();
        test_rr_pair();
        test_manual_stall();
        test_nch3();
`ifdef MUX_RR_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
